// File: rtl/sram_bist_pkg.sv
// Shared types and constants for the March C- SRAM BIST block.
// Element helpers describe the March C- sequence so the FSM stays table-like.
package sram_bist_pkg;

    typedef enum logic [3:0] {
        IDLE,
        E0,
        E1,
        E2,
        E3,
        E4,
        E5,
        DRAIN,
        DONE
    } state_t;

    localparam logic [2:0]  CONF_W32 = 3'b000;
    localparam int unsigned NWORDS   = 512;
    localparam int unsigned AW       = 9;
    localparam logic [9:0]  ERR_MAX  = 10'd1023;

    typedef struct packed {
        logic          valid;
        logic [31:0]   data;
        logic [AW-1:0] addr;
        logic [2:0]    elem;
    } rd_tag_t;

    function automatic logic [2:0] elem_idx(input state_t s);
        case (s)
            E1:      return 3'd1;
            E2:      return 3'd2;
            E3:      return 3'd3;
            E4:      return 3'd4;
            E5:      return 3'd5;
            default: return 3'd0;
        endcase
    endfunction

    function automatic logic is_down(input state_t s);
        return (s == E3) || (s == E4);
    endfunction

    // Reads in E2/E4 expect the inverted background; writes in E1/E3 store it.
    function automatic logic rd_inv(input state_t s);
        return (s == E2) || (s == E4);
    endfunction

    function automatic logic wr_inv(input state_t s);
        return (s == E1) || (s == E3);
    endfunction

    function automatic state_t next_elem(input state_t s);
        case (s)
            E0:      return E1;
            E1:      return E2;
            E2:      return E3;
            E3:      return E4;
            E4:      return E5;
            default: return DRAIN;
        endcase
    endfunction

    function automatic logic [AW-1:0] first_addr(input state_t s);
        return is_down(s) ? AW'(NWORDS - 1) : '0;
    endfunction

endpackage

// File: rtl/sram_bist_rdpipe.sv
// Delay line carrying the expected read word, word address and element index
// alongside the SRAM read latency; a valid tag marks slots holding a real read.
module sram_bist_rdpipe
    import sram_bist_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic          clk,
    input  logic          rstb,
    input  logic          in_valid,
    input  logic [31:0]   in_data,
    input  logic [AW-1:0] in_addr,
    input  logic [2:0]    in_elem,
    output logic          out_valid,
    output logic [31:0]   out_data,
    output logic [AW-1:0] out_addr,
    output logic [2:0]    out_elem
);

    rd_tag_t stage [DEPTH];

    always_ff @(posedge clk) begin
        if (!rstb) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= {in_valid, in_data, in_addr, in_elem};
            for (int unsigned i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign out_valid = stage[DEPTH-1].valid;
    assign out_data  = stage[DEPTH-1].data;
    assign out_addr  = stage[DEPTH-1].addr;
    assign out_elem  = stage[DEPTH-1].elem;

endmodule

// File: rtl/sram_bist.sv
// March C- BIST engine for a 512-word x 32-bit SRAM: one access per cycle,
// pipelined read compare, saturating error count and first-failure capture.
module sram_bist
    import sram_bist_pkg::*;
#(
    parameter logic [31:0] PATTERN = 32'h0000_0000,
    parameter int unsigned RD_LAT  = 2,
    parameter int unsigned OUT_REG = 0
) (
    input  logic        clk,
    input  logic        rstb,
    input  logic        start,
    output logic        csb,
    output logic        web,
    output logic [13:0] addr,
    output logic [2:0]  conf,
    output logic        out_reg,
    output logic [31:0] d_fabric_in,
    input  logic [31:0] d_fabric_out,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [9:0]  err_cnt,
    output logic [8:0]  first_err_addr,
    output logic [2:0]  first_err_elem
);

    localparam int unsigned LAT        = RD_LAT + OUT_REG;
    localparam logic [3:0]  DRAIN_LAST = 4'(LAT - 1);
    localparam logic [AW-1:0] TOP_ADDR = AW'(NWORDS - 1);

    state_t        state, state_nxt;
    logic [AW-1:0] addr_q, addr_nxt;
    logic          phase_q, phase_nxt;
    logic [3:0]    drain_cnt, drain_nxt;
    logic [31:0]   wdata_q;

    logic          start_ok;
    logic          op_read;
    logic          step_done;
    logic          last_addr;
    rd_tag_t       pipe_in;

    logic          pipe_valid;
    logic [31:0]   pipe_data;
    logic [AW-1:0] pipe_addr;
    logic [2:0]    pipe_elem;
    logic          mismatch;

    always_ff @(posedge clk) begin
        if (!rstb) begin
            state     <= IDLE;
            addr_q    <= '0;
            phase_q   <= 1'b0;
            drain_cnt <= '0;
            wdata_q   <= '0;
        end else begin
            state     <= state_nxt;
            addr_q    <= addr_nxt;
            phase_q   <= phase_nxt;
            drain_cnt <= drain_nxt;
            wdata_q   <= d_fabric_in;
        end
    end

    always_comb begin
        state_nxt   = state;
        addr_nxt    = addr_q;
        phase_nxt   = phase_q;
        drain_nxt   = drain_cnt;
        start_ok    = 1'b0;
        op_read     = 1'b0;
        step_done   = 1'b0;
        last_addr   = 1'b0;
        csb         = 1'b1;
        web         = 1'b1;
        d_fabric_in = wdata_q;
        pipe_in     = '0;

        case (state)
            IDLE, DONE: begin
                if (start) begin
                    start_ok  = 1'b1;
                    state_nxt = E0;
                    addr_nxt  = '0;
                    phase_nxt = 1'b0;
                end
            end

            E0, E1, E2, E3, E4, E5: begin
                csb = 1'b0;
                // phase_q selects read (0) or write (1) of the same word in r,w elements
                op_read   = (state == E5) || ((state != E0) && !phase_q);
                step_done = (state == E0) || (state == E5) || phase_q;
                last_addr = is_down(state) ? (addr_q == '0) : (addr_q == TOP_ADDR);
                web       = op_read;

                if (!op_read) begin
                    d_fabric_in = wr_inv(state) ? ~PATTERN : PATTERN;
                end

                pipe_in.valid = op_read;
                pipe_in.data  = rd_inv(state) ? ~PATTERN : PATTERN;
                pipe_in.addr  = addr_q;
                pipe_in.elem  = elem_idx(state);

                if (step_done) begin
                    phase_nxt = 1'b0;
                    if (last_addr) begin
                        state_nxt = next_elem(state);
                        addr_nxt  = first_addr(next_elem(state));
                        drain_nxt = '0;
                    end else begin
                        addr_nxt = is_down(state) ? addr_q - 1'b1 : addr_q + 1'b1;
                    end
                end else begin
                    phase_nxt = 1'b1;
                end
            end

            DRAIN: begin
                if (drain_cnt == DRAIN_LAST) begin
                    state_nxt = DONE;
                end else begin
                    drain_nxt = drain_cnt + 1'b1;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    sram_bist_rdpipe #(
        .DEPTH (LAT)
    ) u_rdpipe (
        .clk       (clk),
        .rstb      (rstb),
        .in_valid  (pipe_in.valid),
        .in_data   (pipe_in.data),
        .in_addr   (pipe_in.addr),
        .in_elem   (pipe_in.elem),
        .out_valid (pipe_valid),
        .out_data  (pipe_data),
        .out_addr  (pipe_addr),
        .out_elem  (pipe_elem)
    );

    assign mismatch = pipe_valid && (pipe_data != d_fabric_out);

    // err_cnt never wraps back to zero, so it doubles as the first-failure flag.
    always_ff @(posedge clk) begin
        if (!rstb) begin
            err_cnt        <= '0;
            first_err_addr <= '0;
            first_err_elem <= '0;
        end else if (start_ok) begin
            err_cnt        <= '0;
            first_err_addr <= '0;
            first_err_elem <= '0;
        end else if (mismatch) begin
            if (err_cnt == '0) begin
                first_err_addr <= pipe_addr;
                first_err_elem <= pipe_elem;
            end
            if (err_cnt != ERR_MAX) begin
                err_cnt <= err_cnt + 1'b1;
            end
        end
    end

    assign addr    = {addr_q, 5'b0_0000};
    assign conf    = CONF_W32;
    assign out_reg = (OUT_REG != 0);
    assign busy    = (state != IDLE) && (state != DONE);
    assign done    = (state == DONE);
    assign pass    = done && (err_cnt == '0);

endmodule

// File: tb/tb_sram_bist.sv
// Self-checking bench: two BIST instances (OUT_REG=0 / OUT_REG=1) each drive a
// behavioural SRAM with injectable read faults; results come from a March C- reference.
module tb_sram_bist;

    localparam logic [31:0] PAT0 = 32'h0000_0000;
    localparam logic [31:0] PAT1 = 32'h5A3C_96E1;

    logic        clk = 1'b0;
    logic        rstb;
    logic        start;
    logic        run_clr;

    logic        csb_v     [2];
    logic        web_v     [2];
    logic [13:0] addr_v    [2];
    logic [2:0]  conf_v    [2];
    logic        outreg_v  [2];
    logic [31:0] din_v     [2];
    logic [31:0] dout_v    [2];
    logic        busy_v    [2];
    logic        done_v    [2];
    logic        pass_v    [2];
    logic [9:0]  errc_v    [2];
    logic [8:0]  fea_v     [2];
    logic [2:0]  fee_v     [2];

    logic [31:0] mem [2][512];
    logic [31:0] rq  [2][4];
    int          opk   [2] = '{0, 0};
    int          opbad [2] = '{0, 0};

    int   fmode = 0;
    int   fword = 0;
    int   fbit  = 0;
    logic fval  = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        sram_bist #(
            .PATTERN (g == 0 ? PAT0 : PAT1),
            .RD_LAT  (2),
            .OUT_REG (g)
        ) u_dut (
            .clk            (clk),
            .rstb           (rstb),
            .start          (start),
            .csb            (csb_v[g]),
            .web            (web_v[g]),
            .addr           (addr_v[g]),
            .conf           (conf_v[g]),
            .out_reg        (outreg_v[g]),
            .d_fabric_in    (din_v[g]),
            .d_fabric_out   (dout_v[g]),
            .busy           (busy_v[g]),
            .done           (done_v[g]),
            .pass           (pass_v[g]),
            .err_cnt        (errc_v[g]),
            .first_err_addr (fea_v[g]),
            .first_err_elem (fee_v[g])
        );
    end

    function automatic logic [31:0] pat(input int g);
        return (g == 0) ? PAT0 : PAT1;
    endfunction

    function automatic logic [31:0] fault_rd(input logic [31:0] v, input int w);
        logic [31:0] r;
        r = v;
        if (fmode == 2) r = '1;
        else if (fmode == 1 && w == fword) r[fbit] = fval;
        return r;
    endfunction

    // Operation k of a March C- run, derived from element sizes alone.
    function automatic void exp_op(input int k, input int g, output logic we_n,
                                   output logic [13:0] a, output logic [31:0] d);
        int e, r, idx;
        logic rd;
        if (k < 512) begin
            e = 0; idx = k; rd = 1'b0;
        end else if (k < 4608) begin
            e = 1 + (k - 512) / 1024;
            r = (k - 512) % 1024;
            idx = r / 2;
            rd = (r % 2 == 0);
        end else begin
            e = 5; idx = k - 4608; rd = 1'b1;
        end
        a    = {9'((e == 3 || e == 4) ? 511 - idx : idx), 5'b0};
        we_n = rd;
        d    = (e == 1 || e == 3) ? ~pat(g) : pat(g);
    endfunction

    function automatic void march_ref(input int g, output int errs, output int fa, output int fe);
        logic [31:0] m [512];
        logic [31:0] want, got;
        errs = 0; fa = 0; fe = 0;
        for (int a = 0; a < 512; a++) m[a] = '0;
        for (int e = 0; e < 6; e++) begin
            for (int i = 0; i < 512; i++) begin
                int a;
                a = (e == 3 || e == 4) ? 511 - i : i;
                if (e != 0) begin
                    want = (e == 2 || e == 4) ? ~pat(g) : pat(g);
                    got  = fault_rd(m[a], a);
                    if (got !== want) begin
                        if (errs == 0) begin
                            fa = a; fe = e;
                        end
                        errs++;
                    end
                end
                if (e != 5) m[a] = (e == 1 || e == 3) ? ~pat(g) : pat(g);
            end
        end
        if (errs > 1023) errs = 1023;
    endfunction

    // SRAM model: accesses sampled at the edge; read data reaches the pins LAT-1 edges later.
    always @(posedge clk) begin
        for (int g = 0; g < 2; g++) begin
            logic [31:0] rv, ed;
            logic        we_n;
            logic [13:0] ea;
            rv = 32'hDEAD_BEEF;
            if (run_clr) begin
                for (int a = 0; a < 512; a++) mem[g][a] <= $urandom;
                opk[g]   <= 0;
                opbad[g] <= 0;
            end else if (csb_v[g] === 1'b0) begin
                if (web_v[g]) rv = fault_rd(mem[g][addr_v[g][13:5]], int'(addr_v[g][13:5]));
                else mem[g][addr_v[g][13:5]] <= din_v[g];
                exp_op(opk[g], g, we_n, ea, ed);
                if (web_v[g] !== we_n || addr_v[g] !== ea || (!we_n && din_v[g] !== ed))
                    opbad[g] <= opbad[g] + 1;
                opk[g] <= opk[g] + 1;
            end
            for (int i = 3; i > 0; i--) rq[g][i] <= rq[g][i-1];
            rq[g][0]  <= rv;
            dout_v[g] <= rq[g][g];
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_march(input string tag, input bit poke);
        int dn [2];
        int errs, fa, fe;
        dn = '{0, 0};
        run_clr = 1'b1;
        start   = 1'b1;
        tick;
        run_clr = 1'b0;
        start   = 1'b0;
        for (int g = 0; g < 2; g++) begin
            chk($sformatf("%s.busy_after_start[%0d]", tag, g), 64'(busy_v[g]), 64'(1));
            chk($sformatf("%s.err_cleared[%0d]", tag, g), 64'(errc_v[g]), 64'(0));
            chk($sformatf("%s.fea_cleared[%0d]", tag, g), 64'(fea_v[g]), 64'(0));
        end
        for (int n = 1; n <= 5300 && (dn[0] == 0 || dn[1] == 0); n++) begin
            start = poke && (n == 300);
            tick;
            for (int g = 0; g < 2; g++)
                if (dn[g] == 0 && done_v[g] === 1'b1) dn[g] = n;
        end
        start = 1'b0;
        for (int g = 0; g < 2; g++) begin
            march_ref(g, errs, fa, fe);
            chk($sformatf("%s.done_cycle[%0d]", tag, g), 64'(dn[g]), 64'(5120 + 2 + g));
            chk($sformatf("%s.err_cnt[%0d]", tag, g), 64'(errc_v[g]), 64'(errs));
            chk($sformatf("%s.pass[%0d]", tag, g), 64'(pass_v[g]), 64'(errs == 0));
            chk($sformatf("%s.first_err_addr[%0d]", tag, g), 64'(fea_v[g]), 64'(fa));
            chk($sformatf("%s.first_err_elem[%0d]", tag, g), 64'(fee_v[g]), 64'(fe));
            chk($sformatf("%s.busy_in_done[%0d]", tag, g), 64'(busy_v[g]), 64'(0));
            chk($sformatf("%s.op_count[%0d]", tag, g), 64'(opk[g]), 64'(5120));
            chk($sformatf("%s.op_errors[%0d]", tag, g), 64'(opbad[g]), 64'(0));
            chk($sformatf("%s.out_reg[%0d]", tag, g), 64'(outreg_v[g]), 64'(g));
            chk($sformatf("%s.conf[%0d]", tag, g), 64'(conf_v[g]), 64'(0));
        end
    endtask

    initial begin
        int saved [2];
        rstb    = 1'b0;
        start   = 1'b0;
        run_clr = 1'b0;
        repeat (3) tick;
        for (int g = 0; g < 2; g++) begin
            chk($sformatf("rst.csb[%0d]", g), 64'(csb_v[g]), 64'(1));
            chk($sformatf("rst.web[%0d]", g), 64'(web_v[g]), 64'(1));
            chk($sformatf("rst.addr[%0d]", g), 64'(addr_v[g]), 64'(0));
            chk($sformatf("rst.din[%0d]", g), 64'(din_v[g]), 64'(0));
            chk($sformatf("rst.busy[%0d]", g), 64'(busy_v[g]), 64'(0));
            chk($sformatf("rst.done[%0d]", g), 64'(done_v[g]), 64'(0));
            chk($sformatf("rst.pass[%0d]", g), 64'(pass_v[g]), 64'(0));
            chk($sformatf("rst.err[%0d]", g), 64'(errc_v[g]), 64'(0));
            chk($sformatf("rst.fea[%0d]", g), 64'(fea_v[g]), 64'(0));
            chk($sformatf("rst.fee[%0d]", g), 64'(fee_v[g]), 64'(0));
        end
        rstb = 1'b1;
        repeat ($urandom_range(1, 5)) tick;

        fmode = 0;
        run_march("clean_poke", 1'b1);

        fmode = 1; fword = 100; fbit = 7; fval = 1'b1;
        run_march("sa1_w100_b7", 1'b0);

        fmode = 1;
        fword = $urandom_range(0, 511);
        fbit  = $urandom_range(0, 31);
        fval  = 1'($urandom_range(0, 1));
        run_march("rand_stuck", 1'b0);

        fmode = 2;
        run_march("all_ones", 1'b0);

        fmode   = 0;
        run_clr = 1'b1;
        start   = 1'b1;
        tick;
        run_clr = 1'b0;
        start   = 1'b0;
        repeat ($urandom_range(1800, 2200)) tick;
        rstb = 1'b0;
        tick;
        rstb = 1'b1;
        for (int g = 0; g < 2; g++) begin
            chk($sformatf("abort.csb[%0d]", g), 64'(csb_v[g]), 64'(1));
            chk($sformatf("abort.busy[%0d]", g), 64'(busy_v[g]), 64'(0));
            chk($sformatf("abort.done[%0d]", g), 64'(done_v[g]), 64'(0));
            chk($sformatf("abort.pass[%0d]", g), 64'(pass_v[g]), 64'(0));
            saved[g] = opk[g];
        end
        repeat (16) tick;
        for (int g = 0; g < 2; g++) begin
            chk($sformatf("abort.no_access[%0d]", g), 64'(opk[g]), 64'(saved[g]));
            chk($sformatf("abort.still_idle[%0d]", g), 64'(done_v[g] | busy_v[g]), 64'(0));
        end

        fmode = 1;
        fword = $urandom_range(0, 511);
        fbit  = $urandom_range(0, 31);
        fval  = 1'($urandom_range(0, 1));
        run_march("after_abort", 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
